// File: rtl/distance_pwm_scheduler.sv
// distance_pwm_scheduler
// Averages windows of distance samples, clamps the average to the PWM top count
// and hands it to the PWM duty input only at a period boundary. The block also
// produces the PWM enable pulse and keeps its own copy of the PWM period counter,
// so it knows where each boundary falls.
module distance_pwm_scheduler #(
  parameter int WIDTH     = 13,
  parameter int MAX_COUNT = 3000,
  parameter int PRESCALE  = 1,
  parameter int LOG2_AVG  = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] sample_data,
  output logic             sample_ready,
  output logic             enable,
  output logic [WIDTH-1:0] duty_cycle,
  output logic             update_pulse,
  output logic             over_range
);

  localparam int ACC_W       = WIDTH + LOG2_AVG;
  localparam int PER_W       = $clog2(MAX_COUNT + 1);
  localparam int PSC_W       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int N_W         = LOG2_AVG + 1;
  localparam int NUM_SAMPLES = 1 << LOG2_AVG;

  localparam logic [PSC_W-1:0] PSC_TOP  = PSC_W'(PRESCALE - 1);
  localparam logic [PER_W-1:0] PER_TOP  = PER_W'(MAX_COUNT);
  localparam logic [WIDTH-1:0] DUTY_MAX = WIDTH'(MAX_COUNT);
  localparam logic [N_W-1:0]   N_LAST   = N_W'(NUM_SAMPLES - 1);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t             state_q,        state_d;
  logic [PSC_W-1:0]   presc_cnt_q,    presc_cnt_d;
  logic               enable_q,       enable_d;
  logic [PER_W-1:0]   period_cnt_q,   period_cnt_d;
  logic [ACC_W-1:0]   acc_q,          acc_d;
  logic [N_W-1:0]     n_q,            n_d;
  logic [WIDTH-1:0]   avg_q,          avg_d;
  logic [WIDTH-1:0]   duty_q,         duty_d;
  logic               over_range_q,   over_range_d;
  logic               update_pulse_q, update_pulse_d;

  logic               boundary;
  logic               accept;
  logic [ACC_W-1:0]   acc_sum;

  // Truncating mean of a full window: the sum divided by the window size.
  function automatic logic [WIDTH-1:0] window_avg(input logic [ACC_W-1:0] sum);
    return WIDTH'(sum >> LOG2_AVG);
  endfunction

  // Saturate an average to the PWM top count; larger averages are off scale.
  function automatic logic [WIDTH-1:0] clamp_duty(input logic [WIDTH-1:0] avg);
    return (avg > DUTY_MAX) ? DUTY_MAX : avg;
  endfunction

  assign sample_ready = (state_q == COLLECT);
  assign accept       = sample_valid && sample_ready;
  assign boundary     = enable_q && (period_cnt_q == PER_TOP);
  assign acc_sum      = acc_q + ACC_W'(sample_data);

  assign enable       = enable_q;
  assign duty_cycle   = duty_q;
  assign update_pulse = update_pulse_q;
  assign over_range   = over_range_q;

  // Next-state logic: prescaler, period mirror, sample window and commit.
  always_comb begin
    state_d        = state_q;
    presc_cnt_d    = presc_cnt_q;
    enable_d       = 1'b0;
    period_cnt_d   = period_cnt_q;
    acc_d          = acc_q;
    n_d            = n_q;
    avg_d          = avg_q;
    duty_d         = duty_q;
    over_range_d   = over_range_q;
    update_pulse_d = 1'b0;

    if (presc_cnt_q == '0) begin
      presc_cnt_d = PSC_TOP;
      enable_d    = 1'b1;
    end else begin
      presc_cnt_d = presc_cnt_q - PSC_W'(1);
    end

    if (enable_q) begin
      period_cnt_d = (period_cnt_q == PER_TOP) ? '0 : period_cnt_q + PER_W'(1);
    end

    case (state_q)
      COLLECT: begin
        if (accept) begin
          acc_d = acc_sum;
          n_d   = n_q + N_W'(1);
          if (n_q == N_LAST) begin
            avg_d   = window_avg(acc_sum);
            state_d = PENDING;
          end
        end
      end
      PENDING: begin
        // Commit lands on the same edge the period counter wraps to zero.
        if (boundary) begin
          duty_d         = clamp_duty(avg_q);
          over_range_d   = (avg_q > DUTY_MAX);
          update_pulse_d = 1'b1;
          acc_d          = '0;
          n_d            = '0;
          state_d        = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // State register; reset discards any pending average immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= COLLECT;
      presc_cnt_q    <= PSC_TOP;
      enable_q       <= 1'b0;
      period_cnt_q   <= '0;
      acc_q          <= '0;
      n_q            <= '0;
      avg_q          <= '0;
      duty_q         <= '0;
      over_range_q   <= 1'b0;
      update_pulse_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      presc_cnt_q    <= presc_cnt_d;
      enable_q       <= enable_d;
      period_cnt_q   <= period_cnt_d;
      acc_q          <= acc_d;
      n_q            <= n_d;
      avg_q          <= avg_d;
      duty_q         <= duty_d;
      over_range_q   <= over_range_d;
      update_pulse_q <= update_pulse_d;
    end
  end

endmodule

// File: tb/tb_distance_pwm_scheduler.sv
// Bench for distance_pwm_scheduler: a window/queue-based reference model
// predicts handshakes, commits and duty values from the block's rules.
module tb_distance_pwm_scheduler;

  localparam int WIDTH     = 13;
  localparam int MAX_COUNT = 3000;
  localparam int AVG_N     = 4;
  localparam int BUDGET    = 3200;

  logic             clk = 1'b0;
  logic             reset_n = 1'b1;
  logic             sample_valid = 1'b0;
  logic [WIDTH-1:0] sample_data = '0;
  logic             sample_ready;
  logic             enable;
  logic [WIDTH-1:0] duty_cycle;
  logic             update_pulse;
  logic             over_range;

  logic             sample_ready4;
  logic             enable4;
  logic [WIDTH-1:0] duty_cycle4;
  logic             update_pulse4;
  logic             over_range4;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  distance_pwm_scheduler #(
    .WIDTH(WIDTH), .MAX_COUNT(MAX_COUNT), .PRESCALE(1), .LOG2_AVG(2)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .sample_valid(sample_valid), .sample_data(sample_data),
    .sample_ready(sample_ready), .enable(enable),
    .duty_cycle(duty_cycle), .update_pulse(update_pulse),
    .over_range(over_range)
  );

  distance_pwm_scheduler #(
    .WIDTH(WIDTH), .MAX_COUNT(MAX_COUNT), .PRESCALE(4), .LOG2_AVG(2)
  ) dut_p4 (
    .clk(clk), .reset_n(reset_n),
    .sample_valid(1'b0), .sample_data('0),
    .sample_ready(sample_ready4), .enable(enable4),
    .duty_cycle(duty_cycle4), .update_pulse(update_pulse4),
    .over_range(over_range4)
  );

  // Reference model (PRESCALE=1): edges since reset release give the period
  // phase directly; accepted samples are kept in a queue until committed.
  int m_edges;
  bit m_pending;
  bit m_upd;
  int m_duty;
  bit m_over;
  int m_avg;
  int win[$];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_edges = 0; m_pending = 0; m_upd = 0;
      m_duty = 0; m_over = 0; m_avg = 0;
      win.delete();
    end else begin
      bit en;
      int per;
      bit bnd;
      int sum;
      en  = (m_edges >= 1);
      per = (m_edges == 0) ? 0 : ((m_edges - 1) % (MAX_COUNT + 1));
      bnd = en && (per == MAX_COUNT);
      m_upd = 0;
      if (m_pending) begin
        if (bnd) begin
          m_duty = (m_avg > MAX_COUNT) ? MAX_COUNT : m_avg;
          m_over = (m_avg > MAX_COUNT);
          m_upd = 1;
          m_pending = 0;
          win.delete();
        end
      end else if (sample_valid) begin
        win.push_back(int'(sample_data));
        if (win.size() == AVG_N) begin
          sum = 0;
          foreach (win[i]) sum += win[i];
          m_avg = sum / AVG_N;
          m_pending = 1;
        end
      end
      m_edges++;
    end
  end

  task automatic send_sample(input int v);
    @(negedge clk);
    sample_valid = 1'b1;
    sample_data  = WIDTH'(v);
  endtask

  task automatic idle_inputs();
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  // Waits (bounded) for the model's commit; reports what it saw on the way.
  task automatic wait_commit(output bit got, output bit ready_bad, output bit duty_bad);
    got = 0; ready_bad = 0; duty_bad = 0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk);
      if (m_upd) begin
        got = 1;
        break;
      end
      if (sample_ready !== 1'b0) ready_bad = 1;
      if (int'(duty_cycle) !== m_duty) duty_bad = 1;
    end
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (duty_cycle !== '0) $display("FAIL reset_duty got %0d want 0", duty_cycle); else n_pass++;
    n_checks++; if (enable !== 1'b0) $display("FAIL reset_enable got %0b want 0", enable); else n_pass++;
    n_checks++; if (update_pulse !== 1'b0) $display("FAIL reset_update got %0b want 0", update_pulse); else n_pass++;
    n_checks++; if (over_range !== 1'b0) $display("FAIL reset_over got %0b want 0", over_range); else n_pass++;
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++; if (sample_ready !== 1'b1) $display("FAIL reset_ready got %0b want 1", sample_ready); else n_pass++;
    n_checks++; if (enable !== 1'b1) $display("FAIL first_enable got %0b want 1", enable); else n_pass++;
  endtask

  task automatic test_prescale();
    int highs, exp_highs;
    bit pattern_bad;
    highs = 0; exp_highs = 0; pattern_bad = 0;
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      bit want;
      @(negedge clk);
      want = ((k % 4) == 0);
      if (want) exp_highs++;
      if (enable4 === 1'b1) highs++;
      if (enable4 !== want) pattern_bad = 1;
    end
    n_checks++; if (highs !== exp_highs) $display("FAIL presc4_count got %0d want %0d", highs, exp_highs); else n_pass++;
    n_checks++; if (pattern_bad !== 1'b0) $display("FAIL presc4_pattern got bad=%0b want 0", pattern_bad); else n_pass++;
  endtask

  task automatic test_average();
    bit got, rb, db;
    send_sample(1000); send_sample(1000); send_sample(2000); send_sample(2000);
    idle_inputs();
    n_checks++; if (sample_ready !== 1'b0) $display("FAIL avg_ready_held got %0b want 0", sample_ready); else n_pass++;
    wait_commit(got, rb, db);
    n_checks++; if (got !== 1'b1) $display("FAIL avg_commit_timeout got %0b want 1", got); else n_pass++;
    n_checks++; if (rb !== 1'b0) $display("FAIL avg_ready_pending got %0b want 0", rb); else n_pass++;
    n_checks++; if (db !== 1'b0) $display("FAIL avg_duty_early got %0b want 0", db); else n_pass++;
    n_checks++; if (duty_cycle !== 13'd1500) $display("FAIL avg_duty got %0d want 1500", duty_cycle); else n_pass++;
    n_checks++; if (update_pulse !== 1'b1) $display("FAIL avg_update got %0b want 1", update_pulse); else n_pass++;
    n_checks++; if (over_range !== 1'b0) $display("FAIL avg_over got %0b want 0", over_range); else n_pass++;
    n_checks++; if (sample_ready !== 1'b1) $display("FAIL avg_ready_after got %0b want 1", sample_ready); else n_pass++;
    @(negedge clk);
    n_checks++; if (update_pulse !== 1'b0) $display("FAIL avg_update_width got %0b want 0", update_pulse); else n_pass++;
  endtask

  task automatic test_clamp();
    bit got, rb, db;
    repeat (4) send_sample(4000);
    idle_inputs();
    wait_commit(got, rb, db);
    n_checks++; if (got !== 1'b1) $display("FAIL clamp_commit_timeout got %0b want 1", got); else n_pass++;
    n_checks++; if (duty_cycle !== 13'd3000) $display("FAIL clamp_duty got %0d want 3000", duty_cycle); else n_pass++;
    n_checks++; if (over_range !== 1'b1) $display("FAIL clamp_over got %0b want 1", over_range); else n_pass++;
    send_sample(100); send_sample(101); send_sample(102); send_sample(103);
    idle_inputs();
    wait_commit(got, rb, db);
    n_checks++; if (got !== 1'b1) $display("FAIL small_commit_timeout got %0b want 1", got); else n_pass++;
    n_checks++; if (db !== 1'b0) $display("FAIL small_duty_early got %0b want 0", db); else n_pass++;
    n_checks++; if (duty_cycle !== 13'd101) $display("FAIL small_duty got %0d want 101", duty_cycle); else n_pass++;
    n_checks++; if (over_range !== 1'b0) $display("FAIL small_over got %0b want 0", over_range); else n_pass++;
    repeat (4) send_sample(3000);
    idle_inputs();
    wait_commit(got, rb, db);
    n_checks++; if (duty_cycle !== 13'd3000) $display("FAIL edge_duty got %0d want 3000", duty_cycle); else n_pass++;
    n_checks++; if (over_range !== 1'b0) $display("FAIL edge_over got %0b want 0", over_range); else n_pass++;
  endtask

  task automatic test_hold_valid();
    bit got, rb, db;
    repeat (4) send_sample(200);
    @(negedge clk);
    sample_data = WIDTH'(7);
    wait_commit(got, rb, db);
    n_checks++; if (got !== 1'b1) $display("FAIL hold_commit_timeout got %0b want 1", got); else n_pass++;
    n_checks++; if (rb !== 1'b0) $display("FAIL hold_ready_pending got %0b want 0", rb); else n_pass++;
    n_checks++; if (duty_cycle !== 13'd200) $display("FAIL hold_first_duty got %0d want 200", duty_cycle); else n_pass++;
    repeat (3) send_sample(9);
    idle_inputs();
    wait_commit(got, rb, db);
    n_checks++; if (got !== 1'b1) $display("FAIL hold_second_timeout got %0b want 1", got); else n_pass++;
    n_checks++; if (duty_cycle !== 13'd8) $display("FAIL hold_duty got %0d want 8", duty_cycle); else n_pass++;
    n_checks++; if (int'(duty_cycle) !== m_duty) $display("FAIL hold_model got %0d want %0d", duty_cycle, m_duty); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit got, rb, db;
    repeat (4) send_sample(4000);
    idle_inputs();
    wait_commit(got, rb, db);
    n_checks++; if (over_range !== 1'b1) $display("FAIL mid_pre_over got %0b want 1", over_range); else n_pass++;
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (duty_cycle !== '0) $display("FAIL mid_duty got %0d want 0", duty_cycle); else n_pass++;
    n_checks++; if (enable !== 1'b0) $display("FAIL mid_enable got %0b want 0", enable); else n_pass++;
    n_checks++; if (update_pulse !== 1'b0) $display("FAIL mid_update got %0b want 0", update_pulse); else n_pass++;
    n_checks++; if (over_range !== 1'b0) $display("FAIL mid_over got %0b want 0", over_range); else n_pass++;
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    n_checks++; if (sample_ready !== 1'b1) $display("FAIL mid_ready got %0b want 1", sample_ready); else n_pass++;
  endtask

  task automatic test_reset_pending();
    bit upd_seen, duty_bad;
    upd_seen = 0; duty_bad = 0;
    repeat (4) send_sample(2500);
    idle_inputs();
    n_checks++; if (sample_ready !== 1'b0) $display("FAIL pend_ready got %0b want 0", sample_ready); else n_pass++;
    #2 reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    for (int i = 0; i < MAX_COUNT + 100; i++) begin
      @(negedge clk);
      if (update_pulse !== 1'b0) upd_seen = 1;
      if (duty_cycle !== '0) duty_bad = 1;
    end
    n_checks++; if (upd_seen !== 1'b0) $display("FAIL pend_update got %0b want 0", upd_seen); else n_pass++;
    n_checks++; if (duty_bad !== 1'b0) $display("FAIL pend_duty got %0b want 0", duty_bad); else n_pass++;
    n_checks++; if (sample_ready !== 1'b1) $display("FAIL pend_ready_after got %0b want 1", sample_ready); else n_pass++;
  endtask

  task automatic test_random();
    bit got, rb, db;
    for (int w = 0; w < 4; w++) begin
      int vals[4];
      int sum, exp_avg, exp_duty;
      bit exp_over;
      sum = 0;
      for (int s = 0; s < 4; s++) begin
        vals[s] = (w == 0) ? int'($urandom_range(3000, 8191)) : int'($urandom_range(0, 8191));
        sum += vals[s];
        repeat ($urandom_range(0, 2)) idle_inputs();
        send_sample(vals[s]);
      end
      idle_inputs();
      exp_avg  = sum / 4;
      exp_over = (exp_avg > MAX_COUNT);
      exp_duty = exp_over ? MAX_COUNT : exp_avg;
      wait_commit(got, rb, db);
      n_checks++; if (got !== 1'b1) $display("FAIL rand%0d_timeout got %0b want 1", w, got); else n_pass++;
      n_checks++; if (rb !== 1'b0) $display("FAIL rand%0d_ready got %0b want 0", w, rb); else n_pass++;
      n_checks++; if (int'(duty_cycle) !== exp_duty) $display("FAIL rand%0d_duty got %0d want %0d", w, duty_cycle, exp_duty); else n_pass++;
      n_checks++; if (int'(duty_cycle) !== m_duty) $display("FAIL rand%0d_model got %0d want %0d", w, duty_cycle, m_duty); else n_pass++;
      n_checks++; if (over_range !== exp_over) $display("FAIL rand%0d_over got %0b want %0b", w, over_range, exp_over); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_prescale();
    test_average();
    test_clamp();
    test_hold_valid();
    test_reset_mid();
    test_reset_pending();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
